// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch sequencer for a multi-cycle, stalling
//            instruction memory. Owns the PC, issues one request at a time,
//            captures the returned word and hands it to decode over a
//            valid/ready handshake. Supports redirect, halt and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] instr_pc2,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        err
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_REQ    = 3'd0,
        S_WAIT   = 3'd1,
        S_HOLD   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
    logic        capture;
    logic        timeout;

    // Timeout fires on the cycle the counter has already reached the limit.
    assign timeout = (cnt_q >= WAIT_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-datapath decode; halt outranks redirect, which outranks normal flow.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            S_REQ: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end else if (!mem_stall) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                if (halt) begin
                    pend_d = 1'b1;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (mem_done) begin
                    // A response landing with a redirect has nothing left outstanding.
                    if (halt || pend_q) begin
                        state_d = S_HALTED;
                    end else if (redirect) begin
                        state_d = S_REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (!halt && redirect) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (halt) begin
                    pend_d = 1'b1;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (mem_done) begin
                    state_d = (halt || pend_q) ? S_HALTED : S_REQ;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 16'd2;
                    state_d = S_REQ;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // PC, wait counter, halt-pending, sticky error and captured instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            cnt_q     <= 8'd0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            instr     <= 16'h0000;
            instr_pc  <= 16'h0000;
            instr_pc2 <= 16'h0002;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            if (capture) begin
                instr     <= mem_rdata;
                instr_pc  <= pc_q;
                instr_pc2 <= pc_q + 16'd2;
            end
        end
    end

    assign mem_en      = (state_q == S_REQ);
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign halted      = (state_q == S_HALTED);
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc2;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic        err;

    int tests = 0;
    int fails = 0;

    fetch_ctrl #(
        .RESET_PC (16'h0000),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_stall   (mem_stall),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_pc2   (instr_pc2),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted),
        .err         (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0; instr_ready = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_mem_en", 16'(mem_en), 16'd1);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_ipc", instr_pc, 16'h0000);
        chk("rst_ipc2", instr_pc2, 16'h0002);

        // Basic fetch: REQ, WAIT, HOLD
        rst = 1'b0; instr_ready = 1'b1;
        tick();
        chk("t1_wait_mem_en", 16'(mem_en), 16'd0);
        mem_done = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_done = 1'b0;
        chk("t1_valid", 16'(instr_valid), 16'd1);
        chk("t1_instr", instr, 16'h1234);
        chk("t1_ipc", instr_pc, 16'h0000);
        chk("t1_ipc2", instr_pc2, 16'h0002);
        tick();
        chk("t1_next_en", 16'(mem_en), 16'd1);
        chk("t1_next_addr", mem_addr, 16'h0002);
        chk("t1_next_valid", 16'(instr_valid), 16'd0);

        // Redirect in REQ to 0x0010, then stall three cycles
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0; mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_en", 16'(mem_en), 16'd1);
            chk("t2_stall_addr", mem_addr, 16'h0010);
            if (i == 3) mem_stall = 1'b0;
            tick();
        end
        chk("t2_wait_en", 16'(mem_en), 16'd0);
        instr_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'hABCD;
        tick();
        mem_done = 1'b0;

        // Decode back-pressure in HOLD
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 16'(instr_valid), 16'd1);
            chk("t3_hold_instr", instr, 16'hABCD);
            chk("t3_hold_ipc", instr_pc, 16'h0010);
            tick();
        end
        chk("t3_still_valid", 16'(instr_valid), 16'd1);
        chk("t3_pc_held", mem_addr, 16'h0010);
        instr_ready = 1'b1;
        tick();
        chk("t3_pc_inc", mem_addr, 16'h0012);
        chk("t3_req_en", 16'(mem_en), 16'd1);

        // Redirect while WAIT: response discarded
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        chk("t4_drain_en", 16'(mem_en), 16'd0);
        chk("t4_drain_valid", 16'(instr_valid), 16'd0);
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_done = 1'b0;
        chk("t4_req_en", 16'(mem_en), 16'd1);
        chk("t4_addr", mem_addr, 16'h0100);
        chk("t4_no_valid", 16'(instr_valid), 16'd0);
        chk("t4_instr_kept", instr, 16'hABCD);
        chk("t4_ipc_kept", instr_pc, 16'h0010);
        tick();
        chk("t4_no_valid2", 16'(instr_valid), 16'd0);

        // Halt while WAIT (state is WAIT at 0x0100 now)
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t5_pend_halted", 16'(halted), 16'd0);
        chk("t5_pend_en", 16'(mem_en), 16'd0);
        mem_done = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_done = 1'b0;
        chk("t5_halted", 16'(halted), 16'd1);
        chk("t5_halt_en", 16'(mem_en), 16'd0);
        chk("t5_halt_valid", 16'(instr_valid), 16'd0);
        chk("t5_no_capture", instr, 16'hABCD);
        redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        tick();
        chk("t5_redir_ignored", mem_addr, 16'h0100);
        chk("t5_still_halted", 16'(halted), 16'd1);
        chk("t5_still_no_en", 16'(mem_en), 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_en", 16'(mem_en), 16'd1);
        chk("t5_rst_addr", mem_addr, 16'h0000);
        chk("t5_rst_halted", 16'(halted), 16'd0);
        chk("t5_rst_instr", instr, 16'h0000);

        // Timeout with MAX_WAIT=4
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_pre_err", 16'(err), 16'd0);
            chk("t6_pre_halted", 16'(halted), 16'd0);
        end
        tick();
        chk("t6_err", 16'(err), 16'd1);
        chk("t6_halted", 16'(halted), 16'd1);
        chk("t6_en", 16'(mem_en), 16'd0);
        tick();
        chk("t6_err_sticky", 16'(err), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_err", 16'(err), 16'd0);

        // PC wrap at 0xFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        chk("t7_addr", mem_addr, 16'hFFFE);
        tick();
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_done = 1'b0;
        chk("t7_instr", instr, 16'hBEEF);
        chk("t7_ipc", instr_pc, 16'hFFFE);
        chk("t7_ipc2", instr_pc2, 16'h0000);
        tick();
        chk("t7_wrap_addr", mem_addr, 16'h0000);
        chk("t7_wrap_en", 16'(mem_en), 16'd1);

        // Halt in HOLD with simultaneous accept: no PC increment
        tick();
        mem_done = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_done = 1'b0;
        chk("t8_hold_valid", 16'(instr_valid), 16'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t8_halted", 16'(halted), 16'd1);
        chk("t8_pc_frozen", mem_addr, 16'h0000);
        chk("t8_err", 16'(err), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
